// File: rtl/rvref_bus_responder.sv
// ============================================================================
// Module   : rvref_bus_responder
// Brief    : Target end of the rvref CPU memory bus. Serves one transaction
//            at a time with a fixed latency, backed by a 31-entry register
//            file (x0 reads as zero) and a word-organised memory.
//            Optional macro RVREF_RESP_BUS_ERROR_EN adds the busError output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rvref_bus_responder #(
  parameter int          MEM_WORDS    = 256,
  parameter int          LATENCY      = 2,
  parameter logic [26:0] REGFILE_BASE = 27'h7000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  input  logic        writeEnable,
  input  logic [3:0]  writeMask,
  input  logic        transactionBegin,
  output logic        transactionEnd
`ifdef RVREF_RESP_BUS_ERROR_EN
  ,
  output logic        busError
`endif
);

  localparam int          c_IDX_W     = $clog2(MEM_WORDS);
  localparam logic [32:0] c_MEM_BYTES = 33'(MEM_WORDS) * 33'd4;
  localparam logic [3:0]  c_LOAD      = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [3:0]  r_count;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_we;
  logic [3:0]  r_mask;

  logic [31:0] r_regs [1:31];
  logic [31:0] r_mem  [0:MEM_WORDS-1];

  logic [4:0]         w_regIdx;
  logic [c_IDX_W-1:0] w_wordIdx;
  logic               w_isReg;
  logic               w_isMem;
  logic               w_commit;
  logic [31:0]        w_readData;

  // Decode of the captured request; address[1:0] never affects memory access
  always_comb begin
    w_regIdx  = r_addr[4:0];
    w_wordIdx = r_addr[c_IDX_W+1:2];
    w_isReg   = (r_addr[31:5] == REGFILE_BASE);
    w_isMem   = !w_isReg && ({1'b0, r_addr} < c_MEM_BYTES);
    w_commit  = (r_state == RESPOND) && r_we;
  end

  // Storage read mux: x0 and out-of-range both read as zero
  always_comb begin
    w_readData = '0;
    if (w_isReg) begin
      if (w_regIdx != 5'd0) begin
        w_readData = r_regs[w_regIdx];
      end
    end else if (w_isMem) begin
      w_readData = r_mem[w_wordIdx];
    end
  end

  // Next-state and bus outputs; data is driven only in the RESPOND cycle of a read
  always_comb begin
    w_nextState    = r_state;
    transactionEnd = 1'b0;
    dataOut        = '0;
    case (r_state)
      IDLE: begin
        if (transactionBegin) begin
          w_nextState = (LATENCY == 1) ? RESPOND : BUSY;
        end
      end
      BUSY: begin
        if (r_count <= 4'd1) begin
          w_nextState = RESPOND;
        end
      end
      RESPOND: begin
        transactionEnd = 1'b1;
        if (!r_we) begin
          dataOut = w_readData;
        end
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State register, latency counter and request capture (only when IDLE)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_we    <= 1'b0;
      r_mask  <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == IDLE) begin
        if (transactionBegin) begin
          r_addr  <= address;
          r_data  <= dataIn;
          r_we    <= writeEnable;
          r_mask  <= writeMask;
          r_count <= c_LOAD;
        end
      end else if (r_state == BUSY) begin
        r_count <= r_count - 4'd1;
      end
    end
  end

  // Register file: full-word writes at the close of RESPOND, x0 writes dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit && w_isReg && (w_regIdx != 5'd0)) begin
      r_regs[w_regIdx] <= r_data;
    end
  end

  // Memory: byte-lane writes at the close of RESPOND; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && w_commit && w_isMem) begin
      for (int b = 0; b < 4; b++) begin
        if (r_mask[b]) begin
          r_mem[w_wordIdx][8*b +: 8] <= r_data[8*b +: 8];
        end
      end
    end
  end

`ifdef RVREF_RESP_BUS_ERROR_EN
  logic r_ignoredBegin;

  // Sticky record of a begin arriving while busy; consumed by the next RESPOND
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ignoredBegin <= 1'b0;
    end else if (transactionBegin && (r_state != IDLE)) begin
      r_ignoredBegin <= 1'b1;
    end else if (r_state == RESPOND) begin
      r_ignoredBegin <= 1'b0;
    end
  end

  // Error flagged on completion of an out-of-range access or after an ignored begin
  always_comb begin
    busError = (r_state == RESPOND) && ((!w_isReg && !w_isMem) || r_ignoredBegin);
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rvref_bus_responder.sv
// ============================================================================
// Module   : tb_rvref_bus_responder
// Brief    : Self-checking bench for rvref_bus_responder (LATENCY=2 main
//            instance, LATENCY=1 secondary instance).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rvref_bus_responder;

  localparam int          LAT  = 2;
  localparam logic [26:0] BASE = 27'h7000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] dataIn = '0;
  logic [31:0] dataOut;
  logic        writeEnable = 1'b0;
  logic [3:0]  writeMask = '0;
  logic        transactionBegin = 1'b0;
  logic        transactionEnd;

  logic [31:0] a1 = '0;
  logic [31:0] d1 = '0;
  logic [31:0] do1;
  logic        we1 = 1'b0;
  logic [3:0]  m1 = '0;
  logic        b1 = 1'b0;
  logic        te1;

`ifdef RVREF_RESP_BUS_ERROR_EN
  logic busErr;
  logic busErr1;
`endif

  rvref_bus_responder #(.MEM_WORDS(256), .LATENCY(LAT), .REGFILE_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .address(address), .dataIn(dataIn), .dataOut(dataOut),
    .writeEnable(writeEnable), .writeMask(writeMask),
    .transactionBegin(transactionBegin), .transactionEnd(transactionEnd)
`ifdef RVREF_RESP_BUS_ERROR_EN
    , .busError(busErr)
`endif
  );

  rvref_bus_responder #(.MEM_WORDS(256), .LATENCY(1), .REGFILE_BASE(BASE)) dut1 (
    .clk(clk), .rst(rst), .address(a1), .dataIn(d1), .dataOut(do1),
    .writeEnable(we1), .writeMask(m1),
    .transactionBegin(b1), .transactionEnd(te1)
`ifdef RVREF_RESP_BUS_ERROR_EN
    , .busError(busErr1)
`endif
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Behavioural model of storage
  logic [31:0] mReg [32];
  logic [31:0] mMem [256];

  function automatic bit mIsReg(input logic [31:0] a);
    return a[31:5] == BASE;
  endfunction

  function automatic bit mOor(input logic [31:0] a);
    return !mIsReg(a) && (a >= 32'd1024);
  endfunction

  function automatic logic [31:0] mRead(input logic [31:0] a);
    if (mIsReg(a)) return (a[4:0] == 5'd0) ? 32'd0 : mReg[a[4:0]];
    if (a < 32'd1024) return mMem[a / 4];
    return 32'd0;
  endfunction

  task automatic mWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] w;
    if (mIsReg(a)) begin
      if (a[4:0] != 5'd0) mReg[a[4:0]] = d;
    end else if (a < 32'd1024) begin
      w = mMem[a / 4];
      for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
      mMem[a / 4] = w;
    end
  endtask

  // One transaction on the main instance; sticky levels are scrambled after begin
  task automatic runTxn(input logic [31:0] a, input logic [31:0] d, input logic we,
                        input logic [3:0] m, output logic [31:0] rd, output int endCnt,
                        output int endAt, output logic err, output logic stray);
    address = a; dataIn = d; writeEnable = we; writeMask = m; transactionBegin = 1'b1;
    @(posedge clk); #1;
    transactionBegin = 1'b0;
    address = ~a; dataIn = ~d; writeEnable = ~we; writeMask = ~m;
    endCnt = 0; endAt = -1; rd = '0; err = 1'b0; stray = 1'b0;
    for (int k = 1; k <= LAT + 3; k++) begin
      if (transactionEnd) begin
        endCnt++; endAt = k; rd = dataOut;
`ifdef RVREF_RESP_BUS_ERROR_EN
        err = busErr;
`endif
      end else if (dataOut != 32'd0) begin
        stray = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic doChecked(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic we, input logic [3:0] m, input logic [31:0] expRd,
                           input logic expErr);
    logic [31:0] rd; int ec; int ea; logic er; logic st;
    runTxn(a, d, we, m, rd, ec, ea, er, st);
    chk({tag, ".endAt"}, ea, LAT);
    chk({tag, ".endCnt"}, ec, 1);
    chk({tag, ".data"}, rd, expRd);
    chk({tag, ".strayData"}, {31'd0, st}, 32'd0);
`ifdef RVREF_RESP_BUS_ERROR_EN
    chk({tag, ".busError"}, {31'd0, er}, {31'd0, expErr});
`else
    if (expErr && 1'b0) chk(tag, 32'd0, 32'd1);
`endif
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] expRd;
    logic        expErr;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [31:0] a, d, e;
    logic [3:0]  m;
    logic        we;
    int          teCnt;

    vecs[0]  = '{32'hE000001F, 32'h0,        1'b0, 4'h0, 32'h0,        1'b0};
    vecs[1]  = '{32'hE0000005, 32'hDEADBEEF, 1'b1, 4'h0, 32'h0,        1'b0};
    vecs[2]  = '{32'hE0000005, 32'h0,        1'b0, 4'h0, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{32'hE0000000, 32'hFFFFFFFF, 1'b1, 4'hF, 32'h0,        1'b0};
    vecs[4]  = '{32'hE0000000, 32'h0,        1'b0, 4'hF, 32'h0,        1'b0};
    vecs[5]  = '{32'h00000010, 32'h11223344, 1'b1, 4'hF, 32'h0,        1'b0};
    vecs[6]  = '{32'h00000010, 32'h000000AA, 1'b1, 4'h1, 32'h0,        1'b0};
    vecs[7]  = '{32'h00000010, 32'h0,        1'b0, 4'h0, 32'h112233AA, 1'b0};
    vecs[8]  = '{32'h00000012, 32'h0,        1'b0, 4'h0, 32'h112233AA, 1'b0};
    vecs[9]  = '{32'h00000010, 32'hFFFFFFFF, 1'b1, 4'h0, 32'h0,        1'b0};
    vecs[10] = '{32'h00000010, 32'h0,        1'b0, 4'hF, 32'h112233AA, 1'b0};
    vecs[11] = '{32'h00001000, 32'h0,        1'b0, 4'h0, 32'h0,        1'b1};
    vecs[12] = '{32'h00001000, 32'h12345678, 1'b1, 4'hF, 32'h0,        1'b1};
    vecs[13] = '{32'h00000020, 32'hCAFE0000, 1'b1, 4'hF, 32'h0,        1'b0};
    vecs[14] = '{32'h00000020, 32'h0,        1'b0, 4'h0, 32'hCAFE0000, 1'b0};

    for (int i = 0; i < 32; i++) mReg[i] = '0;
    for (int i = 0; i < 256; i++) mMem[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset.transactionEnd", {31'd0, transactionEnd}, 32'd0);
    chk("reset.dataOut", dataOut, 32'd0);
    chk("reset.transactionEnd.lat1", {31'd0, te1}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      doChecked($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].we,
                vecs[i].mask, vecs[i].expRd, vecs[i].expErr);
      if (vecs[i].we) mWrite(vecs[i].addr, vecs[i].data, vecs[i].mask);
    end

    // Begin while busy: second request ignored, one completion only
    address = 32'h10; dataIn = '0; writeEnable = 1'b0; writeMask = 4'h0; transactionBegin = 1'b1;
    @(posedge clk); #1;
    teCnt = 0;
    if (transactionEnd) teCnt++;
    address = 32'h10; dataIn = 32'h0; writeEnable = 1'b1; writeMask = 4'hF;
    @(posedge clk); #1;
    transactionBegin = 1'b0;
    chk("busy.endAtT2", {31'd0, transactionEnd}, 32'd1);
    chk("busy.data", dataOut, 32'h112233AA);
`ifdef RVREF_RESP_BUS_ERROR_EN
    chk("busy.busError", {31'd0, busErr}, 32'd1);
`endif
    if (transactionEnd) teCnt++;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (transactionEnd) teCnt++;
    end
    chk("busy.endCnt", teCnt, 1);
    doChecked("busy.noCapture", 32'h10, 32'h0, 1'b0, 4'h0, 32'h112233AA, 1'b0);

    // Reset in the middle of a write: aborted, no completion, no commit
    address = 32'h20; dataIn = 32'h55; writeEnable = 1'b1; writeMask = 4'hF; transactionBegin = 1'b1;
    @(posedge clk); #1;
    transactionBegin = 1'b0;
    teCnt = 0;
    if (transactionEnd) teCnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (transactionEnd) teCnt++;
      @(posedge clk); #1;
    end
    chk("abort.endCnt", teCnt, 0);
    for (int i = 0; i < 32; i++) mReg[i] = '0;
    doChecked("abort.mem", 32'h20, 32'h0, 1'b0, 4'h0, 32'hCAFE0000, 1'b0);
    doChecked("abort.regCleared", 32'hE0000005, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);

    // LATENCY=1 instance
    a1 = 32'hE0000003; d1 = 32'h0BADF00D; we1 = 1'b1; m1 = 4'h0; b1 = 1'b1;
    @(posedge clk); #1;
    b1 = 1'b0;
    chk("lat1.writeEnd", {31'd0, te1}, 32'd1);
    @(posedge clk); #1;
    chk("lat1.oneShot", {31'd0, te1}, 32'd0);
    we1 = 1'b0; b1 = 1'b1;
    @(posedge clk); #1;
    b1 = 1'b0; we1 = 1'b1;
    chk("lat1.readEnd", {31'd0, te1}, 32'd1);
    chk("lat1.data", do1, 32'h0BADF00D);
    @(posedge clk); #1;
    chk("lat1.dataIdle", do1, 32'd0);

    // Randomised traffic against the model: first make words 0..15 known
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      doChecked("init", 32'(w * 4), d, 1'b1, 4'hF, 32'h0, 1'b0);
      mWrite(32'(w * 4), d, 4'hF);
    end
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 2))
        0: a = {BASE, 5'($urandom)};
        1: a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
        default: begin
          a = $urandom | 32'h400;
          if (a[31:5] == BASE) a[31] = 1'b0;
        end
      endcase
      d  = $urandom;
      we = 1'($urandom);
      m  = 4'($urandom);
      e  = we ? 32'h0 : mRead(a);
      doChecked($sformatf("rand%0d", n), a, d, we, m, e, mOor(a));
      if (we) mWrite(a, d, m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rvref_bus_responder.md
Name: rvref_bus_responder

Overview:
- Target end of the CPU memory bus. Answers every transaction the rvref core initiates: instruction fetch, register-file read/write, load and store.
- Holds a 31-entry register file at register-file region base 27'h7000000 (x0 hard-wired to zero) and a word-organised data/instruction memory for all other addresses.
- Single outstanding transaction; fixed, parameterised latency from begin to end.

Parameters:
- MEM_WORDS, 256: memory depth in 32-bit words; must be a power of two.
- LATENCY, 2: cycles from the transactionBegin cycle to the transactionEnd cycle; legal range 1..15.
- REGFILE_BASE, 27'h7000000: value of address[31:5] that selects the register file.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- address  input  32  byte address from initiator
- dataIn  input  32  write data from initiator
- dataOut  output  32  read data to initiator
- writeEnable  input  1  1 = write transaction, sampled only with transactionBegin
- writeMask  input  4  byte-lane enables, bit0 = bits[7:0]; sampled with transactionBegin
- transactionBegin  input  1  one-cycle request strobe
- transactionEnd  output  1  one-cycle completion strobe

Behaviour:
- Reset: transactionEnd=0, dataOut=0, state IDLE, latency counter=0, register file x1..x31 cleared to 0. Memory array is not cleared.
- State machine:
  - IDLE: transactionBegin=1 captures address, dataIn, writeEnable, writeMask; counter loads LATENCY-1; go to BUSY (LATENCY=1: go to RESPOND directly).
  - BUSY: counter decrements each cycle; at 0 go to RESPOND.
  - RESPOND: transactionEnd=1 for exactly this cycle; dataOut valid this cycle only; return to IDLE.
- Timing: begin sampled in cycle T, so transactionEnd=1 in cycle T+LATENCY. dataOut=0 in every cycle except the RESPOND cycle of a read.
- Decode:
  - address[31:5]==REGFILE_BASE selects register file, index address[4:0].
  - Otherwise, address < MEM_WORDS*4 selects memory, word index address[log2(MEM_WORDS)+1:2]; address[1:0] ignored.
  - Anything else is out of range.
- Register-file write: full 32-bit word, writeMask ignored. Writes to index 0 are dropped. Reads of index 0 return 0.
- Memory write: byte lanes with writeMask bit set are updated; writeMask=0 writes nothing but still completes.
- Out-of-range access: read returns 0, write dropped, transaction still completes normally.
- Write commit happens on the clock edge closing the RESPOND cycle. Read data reflects storage contents as of the capture cycle; no hazard is possible with one outstanding transaction.
- transactionBegin while BUSY or RESPOND: ignored, no second completion, no capture.
- writeEnable and writeMask are honoured only in the cycle transactionBegin=1. The initiator leaves these levels sticky between transactions; the responder must not act on them outside that cycle.
- Reset mid-transaction: transaction aborted, no transactionEnd, no write commit, state IDLE next cycle.
- Counter width: 4 bits.

Optional Feature:
- Macro: RVREF_RESP_BUS_ERROR_EN.
- Defined: adds output port busError (1 bit, reset 0). busError=1 in the RESPOND cycle of an out-of-range transaction. A sticky internal flag records any ignored begin-while-busy; that flag also drives busError on the next RESPOND cycle and is then cleared.
- Undefined: port absent, no error logic; all other behaviour identical.

Test Plan:
- LATENCY=2, reset, then write address 0xE0000005, dataIn=0xDEADBEEF, writeEnable=1, writeMask=0 -> transactionEnd at T+2. Subsequent read of 0xE0000005 -> dataOut=0xDEADBEEF in its end cycle.
- Write 0xFFFFFFFF to 0xE0000000, then read 0xE0000000 -> dataOut=0x00000000; transactionEnd asserted both times.
- Memory 0x10: write 0x11223344 with mask 4'hF, then write 0x000000AA with mask 4'h1, then read 0x10 -> 0x112233AA. Read of 0x12 -> 0x112233AA (low bits ignored).
- MEM_WORDS=256, read 0x00001000 -> dataOut=0, transactionEnd=1 at T+2. With macro: busError=1 in that cycle.
- Second transactionBegin at T+1 during a read -> exactly one transactionEnd at T+2, no capture of the second request. With macro: busError=1 on the next completion.
- rst asserted at T+1 of a write of 0x55 to 0x20 -> no transactionEnd, subsequent read of 0x20 returns the prior contents; LATENCY=1 run shows transactionEnd at T+1.
